// File: rtl/nios_gled_seq_pkg.sv
// Shared constants and types for the green-LED pattern sequencer.
package nios_gled_seq_pkg;

    // Config slave word offsets
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_PERIOD = 3'd2;
    localparam logic [2:0] REG_LENGTH = 3'd3;
    localparam logic [2:0] REG_TPTR   = 3'd4;
    localparam logic [2:0] REG_TDATA  = 3'd5;

    // CTRL bit positions
    localparam int CTRL_RUN_BIT      = 0;
    localparam int CTRL_LOOP_BIT     = 1;
    localparam int CTRL_CLR_DONE_BIT = 2;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_IDX_LSB  = 4;

    // idx and TPTR are sized for the largest legal table so the STATUS.idx
    // and TPTR fields keep a fixed 4-bit layout whatever DEPTH is chosen.
    localparam int MAX_DEPTH = 16;
    localparam int IDX_W     = $clog2(MAX_DEPTH);
    localparam int LEN_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT
    } seq_state_e;

endpackage

// File: rtl/nios_gled_seq_table.sv
// Pattern table: one write port, two asynchronous read ports (CPU readback, sequencer fetch).
module nios_gled_seq_table #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] cpu_raddr,
    output logic [DATA_W-1:0]        cpu_rdata,
    input  logic [$clog2(DEPTH)-1:0] seq_raddr,
    output logic [DATA_W-1:0]        seq_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Table write from the config slave
    // NOTE: the table has no reset; software always loads it before starting, and leaving it
    // unreset lets it map onto plain register/LUT storage.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign cpu_rdata = mem_q[cpu_raddr];
    assign seq_rdata = mem_q[seq_raddr];

endmodule

// File: rtl/nios_system_gled_sequencer.sv
// Green-LED sequencer: config slave loads a pattern table, an Avalon master replays it into the PIO.
module nios_system_gled_sequencer
    import nios_gled_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);

    seq_state_e          state_q, state_d;
    logic                run_q, run_d;
    logic                loop_q, loop_d;
    logic                done_q, done_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    tptr_q, tptr_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [LEN_W-1:0]    length_q, length_d;
    logic                m_cs_q, m_cs_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;

    logic                slave_wr;
    logic                ctrl_wr;
    logic                busy;
    logic                run_eff;
    logic                tbl_we;
    logic [DATA_W-1:0]   cpu_rdata;
    logic [DATA_W-1:0]   seq_rdata;

    assign slave_wr = chipselect & ~write_n;
    assign ctrl_wr  = slave_wr && (address == REG_CTRL);
    assign busy     = (state_q != ST_IDLE);

    nios_gled_seq_table #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_table (
        .clk      (clk),
        .we       (tbl_we),
        .waddr    (tptr_q[AW-1:0]),
        .wdata    (writedata[DATA_W-1:0]),
        .cpu_raddr(tptr_q[AW-1:0]),
        .cpu_rdata(cpu_rdata),
        .seq_raddr(idx_d[AW-1:0]),
        .seq_rdata(seq_rdata)
    );

    // Config registers other than CTRL: PERIOD/LENGTH locked while busy, TPTR auto-increments on TDATA
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        period_d = period_q;
        length_d = length_q;
        tptr_d   = tptr_q;
        tbl_we   = 1'b0;
        if (slave_wr) begin
            case (address)
                REG_PERIOD: if (!busy) period_d = writedata[PERIOD_W-1:0];
                REG_LENGTH: if (!busy) length_d = (writedata > 32'(DEPTH)) ? LEN_MAX
                                                                           : writedata[LEN_W-1:0];
                REG_TPTR:   tptr_d = writedata[IDX_W-1:0] & IDX_MASK;
                REG_TDATA: begin
                    tbl_we = 1'b1;
                    tptr_d = (tptr_q + IDX_W'(1)) & IDX_MASK;
                end
                default: ;
            endcase
        end
    end

    // Sequencer next state; CTRL writes apply first, then the FSM may override run/done
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        loop_d  = loop_q;
        done_d  = done_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        run_eff = run_q;

        // A same-cycle stop request is honoured at the WAIT exit, so stop beats completion.
        if (ctrl_wr) begin
            run_d   = writedata[CTRL_RUN_BIT];
            loop_d  = writedata[CTRL_LOOP_BIT];
            run_eff = writedata[CTRL_RUN_BIT];
            if (writedata[CTRL_CLR_DONE_BIT]) begin
                done_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    if (length_q != '0) begin
                        idx_d   = '0;
                        done_d  = 1'b0;
                        state_d = ST_WRITE;
                    end else begin
                        run_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // Never abandon a handshake: leave only once the PIO accepts.
                if (!m_waitrequest) begin
                    cnt_d   = period_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end else if (!run_eff) begin
                    state_d = ST_IDLE;
                end else if ((LEN_W'(idx_q) + LEN_W'(1)) < length_q) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_WRITE;
                end else if (loop_q) begin
                    idx_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    done_d  = 1'b1;
                    run_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered master outputs: entry data is captured on entering WRITE and held until accepted
    always_comb begin
        m_cs_d    = (state_d == ST_WRITE);
        m_wdata_d = '0;
        if (state_d == ST_WRITE) begin
            m_wdata_d = (state_q == ST_WRITE) ? m_wdata_q : seq_rdata;
        end
    end

    // Config slave read mux, zero latency
    always_comb begin
        readdata = '0;
        case (address)
            REG_CTRL: begin
                readdata[CTRL_RUN_BIT]  = run_q;
                readdata[CTRL_LOOP_BIT] = loop_q;
            end
            REG_STATUS: begin
                readdata[STAT_BUSY_BIT]              = busy;
                readdata[STAT_DONE_BIT]              = done_q;
                readdata[STAT_IDX_LSB +: IDX_W]      = idx_q;
            end
            REG_PERIOD: readdata[PERIOD_W-1:0] = period_q;
            REG_LENGTH: readdata[LEN_W-1:0]    = length_q;
            REG_TPTR:   readdata[IDX_W-1:0]    = tptr_q;
            REG_TDATA:  readdata[DATA_W-1:0]   = cpu_rdata;
            default:    readdata = '0;
        endcase
    end

    // State registers; async reset drops the master strobe immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            loop_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            tptr_q    <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            length_q  <= '0;
            m_cs_q    <= 1'b0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            loop_q    <= loop_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            tptr_q    <= tptr_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            length_q  <= length_d;
            m_cs_q    <= m_cs_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_address    = 2'b00;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = ~m_cs_q;
    assign m_writedata  = {{(32 - DATA_W){1'b0}}, m_wdata_q};

endmodule

// File: tb/tb_nios_system_gled_sequencer.sv
// Directed bench for the green-LED sequencer; PIO accepts are logged and compared to hand-derived values.
module tb_nios_system_gled_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] acc_data [$];
    int          acc_cyc  [$];

    nios_system_gled_sequencer #(
        .DEPTH   (8),
        .DATA_W  (8),
        .PERIOD_W(24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every accepted PIO write (data and cycle index), sampled mid-cycle
    always @(negedge clk) begin
        if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
            acc_data.push_back(m_writedata);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] data_at(input int i);
        return (i < acc_data.size()) ? acc_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -1000;
    endfunction

    task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d, output int wcyc);
        @(posedge clk); #1;
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        wcyc = cyc;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a;
        #1 d = readdata;
    endtask

    task automatic wait_acc(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (acc_data.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(tag, 32'(acc_data.size()), 32'(n));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        int          c0;
        int          wc;
        int          k;
        logic [31:0] rd;

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; m_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_cs",    32'(m_chipselect), 32'd0);
        check("rst_wn",    32'(m_write_n),    32'd1);
        check("rst_wdata", m_writedata,       32'd0);
        check("rst_maddr", 32'(m_address),    32'd0);
        cpu_rd(3'd0, rd); check("rst_ctrl",   rd, 32'd0);
        cpu_rd(3'd1, rd); check("rst_status", rd, 32'd0);
        cpu_rd(3'd2, rd); check("rst_period", rd, 32'd0);
        cpu_rd(3'd3, rd); check("rst_length", rd, 32'd0);
        cpu_rd(3'd4, rd); check("rst_tptr",   rd, 32'd0);

        // One-shot sequence {01,02,04}, PERIOD=4: accepts 6 cycles apart
        cpu_wr(3'd4, 32'd0, wc);
        cpu_wr(3'd5, 32'h01, wc);
        cpu_wr(3'd5, 32'h02, wc);
        cpu_wr(3'd5, 32'h04, wc);
        cpu_wr(3'd3, 32'd3, wc);
        cpu_wr(3'd2, 32'd4, wc);
        clear_log();
        cpu_wr(3'd0, 32'h1, c0);
        wait_acc("t1_count", 3, 100);
        check("t1_d0",  data_at(0), 32'h01);
        check("t1_d1",  data_at(1), 32'h02);
        check("t1_d2",  data_at(2), 32'h04);
        check("t1_lat", 32'(cyc_at(0) - c0),        32'd2);
        check("t1_sp1", 32'(cyc_at(1) - cyc_at(0)), 32'd6);
        check("t1_sp2", 32'(cyc_at(2) - cyc_at(1)), 32'd6);
        idle_cycles(10);
        cpu_rd(3'd1, rd); check("t1_status", rd, 32'h22);
        cpu_rd(3'd0, rd); check("t1_ctrl",   rd, 32'h0);
        check("t1_no_extra", 32'(acc_data.size()), 32'd3);

        // Loop mode, wrap to idx 0, then stop mid-WAIT
        clear_log();
        cpu_wr(3'd0, 32'h3, c0);
        wait_acc("t2_count", 5, 200);
        cpu_wr(3'd0, 32'h2, wc);
        idle_cycles(20);
        check("t2_d3",   data_at(3), 32'h01);
        check("t2_d4",   data_at(4), 32'h02);
        check("t2_wrap", 32'(cyc_at(3) - cyc_at(2)), 32'd6);
        check("t2_stopped", 32'(acc_data.size()), 32'd5);
        cpu_rd(3'd1, rd); check("t2_status", rd, 32'h10);

        // Stall the second write for 5 cycles
        clear_log();
        cpu_wr(3'd0, 32'h1, c0);
        wait_acc("t3_first", 1, 50);
        @(posedge clk); #1 m_waitrequest = 1'b1;
        k = 0;
        while (!m_chipselect && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t3_cs_seen", 32'(m_chipselect), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", {m_chipselect, m_write_n, m_writedata[29:0]}, {1'b1, 1'b0, 30'h2});
            @(posedge clk); #1;
        end
        m_waitrequest = 1'b0;
        wait_acc("t3_count", 3, 100);
        check("t3_d1",     data_at(1), 32'h02);
        check("t3_stall",  32'(cyc_at(1) - cyc_at(0)), 32'd11);
        check("t3_period", 32'(cyc_at(2) - cyc_at(1)), 32'd6);
        idle_cycles(10);
        cpu_rd(3'd1, rd); check("t3_status", rd, 32'h22);

        // LENGTH=0 start: no master activity, done after one cycle; clr_done; LENGTH clamp
        clear_log();
        cpu_wr(3'd3, 32'd0, wc);
        cpu_wr(3'd0, 32'h4, wc);
        cpu_rd(3'd1, rd); check("t4_clr_done", rd, 32'h20);
        cpu_wr(3'd0, 32'h1, c0);
        check("t4_run_seen", readdata, 32'h1);
        cpu_rd(3'd0, rd); check("t4_run_clr", rd, 32'h0);
        cpu_rd(3'd1, rd); check("t4_done",    rd, 32'h22);
        idle_cycles(10);
        check("t4_no_master", 32'(acc_data.size()), 32'd0);
        cpu_wr(3'd3, 32'd20, wc);
        cpu_rd(3'd3, rd); check("t4_len_clamp", rd, 32'd8);

        // TPTR wrap and TDATA readback without increment
        cpu_wr(3'd4, 32'd7, wc);
        cpu_wr(3'd5, 32'hAA, wc);
        cpu_wr(3'd5, 32'hBB, wc);
        cpu_rd(3'd4, rd); check("t5_tptr_wrap", rd, 32'd1);
        cpu_rd(3'd5, rd); check("t5_tdata_rd1", rd, 32'h02);
        cpu_rd(3'd5, rd); check("t5_tdata_rd2", rd, 32'h02);
        cpu_rd(3'd4, rd); check("t5_tptr_hold", rd, 32'd1);
        cpu_wr(3'd4, 32'd7, wc);
        cpu_rd(3'd5, rd); check("t5_tab7", rd, 32'hAA);
        cpu_wr(3'd4, 32'd0, wc);
        cpu_rd(3'd5, rd); check("t5_tab0", rd, 32'hBB);

        // Busy-time writes: PERIOD/LENGTH ignored, TDATA lands on next fetch
        cpu_wr(3'd3, 32'd2, wc);
        cpu_wr(3'd2, 32'd10, wc);
        clear_log();
        cpu_wr(3'd0, 32'h3, c0);
        wait_acc("t5_first", 1, 50);
        cpu_wr(3'd4, 32'd1, wc);
        cpu_wr(3'd5, 32'h55, wc);
        cpu_wr(3'd2, 32'd3, wc);
        cpu_rd(3'd2, rd); check("t5_period_lock", rd, 32'd10);
        cpu_wr(3'd3, 32'd5, wc);
        cpu_rd(3'd3, rd); check("t5_length_lock", rd, 32'd2);
        wait_acc("t5_count", 3, 200);
        check("t5_d0",  data_at(0), 32'hBB);
        check("t5_d1",  data_at(1), 32'h55);
        check("t5_d2",  data_at(2), 32'hBB);
        check("t5_sp",  32'(cyc_at(1) - cyc_at(0)), 32'd12);
        cpu_wr(3'd0, 32'h0, wc);
        idle_cycles(30);
        cpu_rd(3'd1, rd); check("t5_idle", rd & 32'h3, 32'h0);

        // Async reset in the middle of a stalled WRITE
        m_waitrequest = 1'b1;
        cpu_wr(3'd0, 32'h1, c0);
        k = 0;
        while (!m_chipselect && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t6_cs_before", 32'(m_chipselect), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_cs_drop", 32'(m_chipselect), 32'd0);
        check("t6_wn_high", 32'(m_write_n),    32'd1);
        check("t6_wdata",   m_writedata,       32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; m_waitrequest = 1'b0;
        cpu_rd(3'd0, rd); check("t6_ctrl",   rd, 32'd0);
        cpu_rd(3'd1, rd); check("t6_status", rd, 32'd0);
        cpu_rd(3'd2, rd); check("t6_period", rd, 32'd0);
        cpu_rd(3'd3, rd); check("t6_length", rd, 32'd0);
        cpu_rd(3'd4, rd); check("t6_tptr",   rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
